mem_load_unit: RTL and testbench

MEM_LOAD_UNIT -- requirements
Module: mem_load_unit

---
 rtl/mem_pkg.sv | 39 +++
 rtl/load_extract.sv | 37 +++
 rtl/mem_load_unit.sv | 150 +++++++++++++++
 tb/tb_mem_load_unit.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the load unit.
//   - address-space codes (ALU_out[31:28])
//   - load-type codes and the decode of the raw 3-bit MemRead field
//   - load-unit FSM state encoding
//   - misalignment helper
package mem_pkg;

    localparam logic [3:0] SPC_DMEM     = 4'b0001;
    localparam logic [3:0] SPC_IMEM     = 4'b0010;
    localparam logic [3:0] SPC_DMEM_ALT = 4'b0011;
    localparam logic [3:0] SPC_BIOS     = 4'b0100;
    localparam logic [3:0] SPC_IO       = 4'b1000;

    typedef enum logic [2:0] {
        LD_NONE = 3'd0,
        LD_LB   = 3'd1,
        LD_LH   = 3'd2,
        LD_LW   = 3'd3,
        LD_LBU  = 3'd4,
        LD_LHU  = 3'd5
    } ld_type_e;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_IO_WAIT = 1'b1
    } lsu_state_e;

    // Codes 6 and 7 are unused encodings and behave as no load.
    function automatic ld_type_e decode_ld(input logic [2:0] raw);
        if (raw > 3'd5) return LD_NONE;
        return ld_type_e'(raw);
    endfunction

    function automatic logic is_misaligned(input ld_type_e t, input logic [1:0] off);
        return ((t == LD_LW) && (off != 2'b00)) ||
               (((t == LD_LH) || (t == LD_LHU)) && off[0]);
    endfunction

endpackage

// File: rtl/load_extract.sv
// load_extract: combinational byte/half/word select plus sign/zero extension.
//   ld_type  : load type code (mem_pkg::ld_type_e values)
//   offset   : byte offset within the word
//   word_in  : raw 32-bit read word
//   data_out : aligned, extended result (0 for no load)
module load_extract
    import mem_pkg::*;
(
    input  logic [2:0]  ld_type,
    input  logic [1:0]  offset,
    input  logic [31:0] word_in,
    output logic [31:0] data_out
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        case (offset)
            2'd0:    byte_v = word_in[7:0];
            2'd1:    byte_v = word_in[15:8];
            2'd2:    byte_v = word_in[23:16];
            default: byte_v = word_in[31:24];
        endcase
        half_v = offset[1] ? word_in[31:16] : word_in[15:0];

        case (ld_type)
            LD_LB:   data_out = {{24{byte_v[7]}}, byte_v};
            LD_LBU:  data_out = {24'b0, byte_v};
            LD_LH:   data_out = {{16{half_v[15]}}, half_v};
            LD_LHU:  data_out = {16'b0, half_v};
            LD_LW:   data_out = word_in;
            default: data_out = 32'b0;
        endcase
    end

endmodule

// File: rtl/mem_load_unit.sv
// mem_load_unit: MEM-stage load path. Captures the EX-stage load, selects the
// read source by address space, aligns/extends the result, and runs a small
// IDLE/IO_WAIT FSM for variable-latency IO reads.
//   clk, rst         : clock, synchronous active-low reset
//   stall, flush     : pipeline hold / kill of the in-flight load
//   ALU_out          : EX effective address;  MemRead_EX : EX load type
//   DMem_Data_R      : DMem read data (1-cycle); bios_Data_R : BIOS read data
//   IO_Data_R        : IO read data, valid with IO_rd_ack
//   IO_rd_req/addr   : IO read request (level) and word address
//   Load_Data/valid  : load result and its valid
//   Load_stall       : stall request while IO read pending
//   Load_misaligned  : misaligned-load flag
// Optional feature macro: LOAD_MISALIGN_TRAP_EN (flag and zero misaligned
// loads, and keep misaligned IO loads off the IO bus).
module mem_load_unit
    import mem_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] ALU_out,
    input  logic [2:0]  MemRead_EX,
    input  logic [31:0] DMem_Data_R,
    input  logic [31:0] bios_Data_R,
    input  logic [31:0] IO_Data_R,
    input  logic        IO_rd_ack,
    output logic        IO_rd_req,
    output logic [13:0] IO_rd_addr,
    output logic [31:0] Load_Data,
    output logic        Load_valid,
    output logic        Load_stall,
    output logic        Load_misaligned
);

    ld_type_e   type_q, type_d, new_type;
    logic [1:0] off_q, off_d;
    logic [3:0] spc_q, spc_d;
    logic [13:0] waddr_q, waddr_d;
    lsu_state_e state_q, state_d;
    logic       hold_vld_q, hold_vld_d;
    logic [31:0] hold_data_q, hold_data_d;

    logic        io_wait, io_busy, cap_en, new_io, new_trap, trap_mis, valid_raw;
    logic [31:0] raw_word, ext_data, data_raw;
    logic        unused_addr;

    assign unused_addr = ^ALU_out[27:16];

`ifdef LOAD_MISALIGN_TRAP_EN
    assign new_trap = is_misaligned(new_type, ALU_out[1:0]);
    assign trap_mis = is_misaligned(type_q, off_q);
`else
    assign new_trap = 1'b0;
    assign trap_mis = 1'b0;
`endif

    // Capture / FSM next-state
    always_comb begin
        new_type = decode_ld(MemRead_EX);
        io_wait  = (state_q == ST_IO_WAIT);
        io_busy  = io_wait & ~IO_rd_ack;
        // A pending IO read holds the captured load even if the pipeline
        // has not yet reacted to Load_stall.
        cap_en   = ~stall & ~io_busy;
        new_io   = (new_type != LD_NONE) && (ALU_out[31:28] == SPC_IO) && !new_trap;

        type_d  = type_q;
        off_d   = off_q;
        spc_d   = spc_q;
        waddr_d = waddr_q;
        if (cap_en) begin
            type_d  = new_type;
            off_d   = ALU_out[1:0];
            spc_d   = ALU_out[31:28];
            waddr_d = ALU_out[15:2];
        end
        if (flush) type_d = LD_NONE;

        // The ack edge normally returns to IDLE; a back-to-back IO load
        // captured on that same edge goes straight into its own wait.
        if (flush)                  state_d = ST_IDLE;
        else if (io_busy)           state_d = ST_IO_WAIT;
        else if (cap_en && new_io)  state_d = ST_IO_WAIT;
        else                        state_d = ST_IDLE;
    end

    // Source select and result
    always_comb begin
        case (spc_q)
            SPC_DMEM, SPC_DMEM_ALT: raw_word = DMem_Data_R;
            SPC_BIOS:               raw_word = bios_Data_R;
            SPC_IO:                 raw_word = IO_Data_R;
            default:                raw_word = 32'b0;
        endcase

        if (type_q == LD_NONE)   valid_raw = 1'b0;
        else if (io_wait)        valid_raw = IO_rd_ack & ~flush;
        else if (spc_q == SPC_IO) valid_raw = trap_mis;  // trapped IO load never waits
        else                     valid_raw = 1'b1;

        data_raw = (valid_raw && !trap_mis) ? ext_data : 32'b0;

        // Freeze the first valid result seen under stall; memory read
        // data is free to change while the pipeline is held.
        hold_vld_d  = hold_vld_q;
        hold_data_d = hold_data_q;
        if (!stall) begin
            hold_vld_d = 1'b0;
        end else if (!hold_vld_q && valid_raw) begin
            hold_vld_d  = 1'b1;
            hold_data_d = data_raw;
        end
    end

    load_extract u_extract (
        .ld_type  (type_q),
        .offset   (off_q),
        .word_in  (raw_word),
        .data_out (ext_data)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            type_q      <= LD_NONE;
            off_q       <= 2'b0;
            spc_q       <= 4'b0;
            waddr_q     <= 14'b0;
            hold_vld_q  <= 1'b0;
            hold_data_q <= 32'b0;
        end else begin
            state_q     <= state_d;
            type_q      <= type_d;
            off_q       <= off_d;
            spc_q       <= spc_d;
            waddr_q     <= waddr_d;
            hold_vld_q  <= hold_vld_d;
            hold_data_q <= hold_data_d;
        end
    end

    assign IO_rd_req       = io_wait;
    assign IO_rd_addr      = waddr_q;
    assign Load_stall      = io_busy;
    assign Load_valid      = hold_vld_q | valid_raw;
    assign Load_Data       = hold_vld_q ? hold_data_q : data_raw;
    assign Load_misaligned = trap_mis & Load_valid;

endmodule

// File: tb/tb_mem_load_unit.sv
module tb_mem_load_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0, flush = 1'b0;
    logic [31:0] ALU_out = '0;
    logic [2:0]  MemRead_EX = '0;
    logic [31:0] DMem_Data_R = '0, bios_Data_R = '0, IO_Data_R = '0;
    logic        IO_rd_ack = 1'b0;
    logic        IO_rd_req;
    logic [13:0] IO_rd_addr;
    logic [31:0] Load_Data;
    logic        Load_valid, Load_stall, Load_misaligned;

    mem_load_unit dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .ALU_out(ALU_out), .MemRead_EX(MemRead_EX),
        .DMem_Data_R(DMem_Data_R), .bios_Data_R(bios_Data_R),
        .IO_Data_R(IO_Data_R), .IO_rd_ack(IO_rd_ack),
        .IO_rd_req(IO_rd_req), .IO_rd_addr(IO_rd_addr),
        .Load_Data(Load_Data), .Load_valid(Load_valid),
        .Load_stall(Load_stall), .Load_misaligned(Load_misaligned)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic        v;
        logic [31:0] d;
        logic        m;
    } exp_t;

    exp_t sbq[$];
    int n_cmp = 0;
    int n_bad = 0;

`ifdef LOAD_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic v, input logic [31:0] d, input logic m);
        exp_t e;
        e.tag = tag; e.v = v; e.d = d; e.m = m;
        sbq.push_back(e);
    endtask

    task automatic check_sb();
        exp_t e;
        if (sbq.size() == 0) begin
            n_cmp++;
            n_bad++;
            $error("FAIL sb_empty: observed 0 entries expected 1");
        end else begin
            e = sbq.pop_front();
            chk({e.tag, "_valid"}, {31'b0, Load_valid}, {31'b0, e.v});
            chk({e.tag, "_data"},  Load_Data, e.d);
            chk({e.tag, "_mis"},   {31'b0, Load_misaligned}, {31'b0, e.m});
        end
    endtask

    // Drive a load in EX, capture it, present memory data, check result.
    task automatic mem_load(input string tag, input logic [2:0] t, input logic [31:0] a,
                            input logic [31:0] dmem, input logic [31:0] bios,
                            input logic v, input logic [31:0] d, input logic m);
        MemRead_EX = t;
        ALU_out    = a;
        tick();
        MemRead_EX  = 3'd0;
        DMem_Data_R = dmem;
        bios_Data_R = bios;
        push(tag, v, d, m);
        #1;
        check_sb();
    endtask

    task automatic enter_io(input logic [31:0] a);
        MemRead_EX = 3'd3;
        ALU_out    = a;
        tick();
        MemRead_EX = 3'd0;
        #1;
    endtask

    initial begin
        // reset
        tick(); tick();
        push("reset", 1'b0, 32'h0, 1'b0);
        check_sb();
        chk("reset_io_req", {31'b0, IO_rd_req}, 32'd0);
        chk("reset_stall",  {31'b0, Load_stall}, 32'd0);
        rst = 1'b1;

        mem_load("lb_neg",   3'd1, 32'h1000_0003, 32'h8000_0000, 32'h0, 1'b1, 32'hFFFF_FF80, 1'b0);
        mem_load("lhu_bios", 3'd5, 32'h4000_0002, 32'h0, 32'hBEEF_1234, 1'b1, 32'h0000_BEEF, 1'b0);
        mem_load("lbu_b1",   3'd4, 32'h1000_0001, 32'h0000_8F00, 32'h0, 1'b1, 32'h0000_008F, 1'b0);
        mem_load("lh_alt",   3'd2, 32'h3000_0000, 32'h1234_8001, 32'h0, 1'b1, 32'hFFFF_8001, 1'b0);
        mem_load("lw_dmem",  3'd3, 32'h1000_0004, 32'hDEAD_BEEF, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0);
        mem_load("lw_other", 3'd3, 32'h2000_0000, 32'hDEAD_BEEF, 32'h0, 1'b1, 32'h0, 1'b0);
        mem_load("type6",    3'd6, 32'h1000_0000, 32'hDEAD_BEEF, 32'h0, 1'b0, 32'h0, 1'b0);
        mem_load("lw_mis",   3'd3, 32'h1000_0002, 32'hA5A5_5A5A, 32'h0,
                 1'b1, TRAP ? 32'h0 : 32'hA5A5_5A5A, TRAP);
        mem_load("lh_mis",   3'd2, 32'h1000_0001, 32'h0000_7FFF, 32'h0,
                 1'b1, TRAP ? 32'h0 : 32'h0000_7FFF, TRAP);
        tick();
        push("none_after", 1'b0, 32'h0, 1'b0);
        check_sb();

        // IO load, ack after 3 waiting cycles
        enter_io(32'h8000_0010);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("io_req_c%0d", i),   {31'b0, IO_rd_req}, 32'd1);
            chk($sformatf("io_stall_c%0d", i), {31'b0, Load_stall}, 32'd1);
            chk($sformatf("io_valid_c%0d", i), {31'b0, Load_valid}, 32'd0);
            chk($sformatf("io_addr_c%0d", i),  {18'b0, IO_rd_addr}, 32'h0004);
            tick(); #1;
        end
        IO_rd_ack = 1'b1;
        IO_Data_R = 32'h1234_5678;
        push("io_ack", 1'b1, 32'h1234_5678, 1'b0);
        #1;
        check_sb();
        chk("io_ack_stall", {31'b0, Load_stall}, 32'd0);
        tick();
        IO_rd_ack = 1'b0;
        #1;
        chk("io_done_req", {31'b0, IO_rd_req}, 32'd0);

        // flush coinciding with ack
        enter_io(32'h8000_0020);
        tick(); #1;
        flush = 1'b1; IO_rd_ack = 1'b1; IO_Data_R = 32'hFFFF_0000;
        #1;
        chk("flush_ack_valid", {31'b0, Load_valid}, 32'd0);
        tick();
        flush = 1'b0; IO_rd_ack = 1'b0;
        #1;
        chk("flush_req_drop", {31'b0, IO_rd_req}, 32'd0);
        chk("flush_stall",    {31'b0, Load_stall}, 32'd0);
        mem_load("post_flush", 3'd3, 32'h1000_0000, 32'h0BAD_F00D, 32'h0, 1'b1, 32'h0BAD_F00D, 1'b0);

        // reset while waiting; a late ack must be ignored
        enter_io(32'h8000_0030);
        chk("rstw_req_before", {31'b0, IO_rd_req}, 32'd1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        IO_rd_ack = 1'b1; IO_Data_R = 32'h5555_AAAA;
        #1;
        chk("rstw_valid", {31'b0, Load_valid}, 32'd0);
        chk("rstw_req",   {31'b0, IO_rd_req}, 32'd0);
        tick();
        IO_rd_ack = 1'b0;
        #1;
        chk("rstw_idle_req", {31'b0, IO_rd_req}, 32'd0);

        // misaligned IO load
        enter_io(32'h8000_0011);
        if (TRAP) begin
            push("io_mis", 1'b1, 32'h0, 1'b1);
            check_sb();
            chk("io_mis_req", {31'b0, IO_rd_req}, 32'd0);
        end else begin
            chk("io_mis_req", {31'b0, IO_rd_req}, 32'd1);
            IO_rd_ack = 1'b1; IO_Data_R = 32'h0F0F_0F0F;
            push("io_mis", 1'b1, 32'h0F0F_0F0F, 1'b0);
            #1;
            check_sb();
            tick();
            IO_rd_ack = 1'b0;
            #1;
        end
        tick(); #1;

        // stall holds the result while DMem data moves
        MemRead_EX = 3'd3; ALU_out = 32'h1000_0008;
        tick();
        MemRead_EX = 3'd0; DMem_Data_R = 32'hCAFE_F00D; stall = 1'b1;
        push("stall_c0", 1'b1, 32'hCAFE_F00D, 1'b0);
        #1;
        check_sb();
        tick();
        DMem_Data_R = 32'h1111_1111;
        push("stall_c1", 1'b1, 32'hCAFE_F00D, 1'b0);
        #1;
        check_sb();
        tick();
        DMem_Data_R = 32'h2222_2222;
        push("stall_c2", 1'b1, 32'hCAFE_F00D, 1'b0);
        #1;
        check_sb();
        stall = 1'b0;
        tick();
        push("stall_rel", 1'b0, 32'h0, 1'b0);
        #1;
        check_sb();

        chk("sb_drained", sbq.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
